hazard_unit: RTL and testbench

Hazard-detection and forwarding block for the five-stage pipelined CPU; it is the producer of the `Branch` and `ControlSrc` inputs consumed by the control unit. It keeps its own shadow pipeline of register-write information for the EX, MEM and WB stages, detects load-use hazards and taken branches, and drives the EX-stage operand forwarding selects. It also keeps saturating stall/flush counters and a sticky halt flag for debug.

---
 rtl/hazard_unit.sv | 147 ++++++++++++++
 tb/tb_hazard_unit.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, branch flush and EX operand forwarding for the 5-stage pipeline
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_WriteReg,
    input  logic             ID_RegWre,
    input  logic             ID_MemRead,
    input  logic             ID_Halt,
    input  logic             MEM_BranchTaken,
    output logic             Branch,
    output logic             ControlSrc,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             Halted
);

    typedef struct packed {
        logic       valid;
        logic [4:0] write_reg;
        logic       reg_wre;
        logic       mem_read;
        logic       halt;
    } stage_t;

    stage_t     id_s;
    stage_t     ex_q;
    stage_t     mem_q;
    stage_t     wb_q;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_uses_rs;
    logic       ex_uses_rt;

    logic       load_hit;
    logic       mem_fwd;
    logic       wb_fwd;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        id_s           = '0;
        id_s.valid     = ID_Valid;
        id_s.write_reg = ID_WriteReg;
        id_s.reg_wre   = ID_RegWre;
        id_s.mem_read  = ID_MemRead;
        id_s.halt      = ID_Halt;
    end

    // A nonzero EX destination can only match a nonzero source, so $0 never stalls.
    always_comb begin
        load_hit = 1'b0;
        if (ex_q.valid && ex_q.mem_read && (ex_q.write_reg != 5'd0)) begin
            load_hit = ((ex_q.write_reg == ID_Rs) && ID_UsesRs) ||
                       ((ex_q.write_reg == ID_Rt) && ID_UsesRt);
        end
    end

    assign Branch     = MEM_BranchTaken & mem_q.valid;
    assign ControlSrc = ID_Valid & load_hit & ~Branch;

    // Loads in MEM have no data yet; the stall ensures they are picked up from WB.
    assign mem_fwd = mem_q.valid & mem_q.reg_wre & (mem_q.write_reg != 5'd0) & ~mem_q.mem_read;
    assign wb_fwd  = wb_q.valid & wb_q.reg_wre & (wb_q.write_reg != 5'd0);

    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (ex_q.valid && ex_uses_rs) begin
            if (mem_fwd && (mem_q.write_reg == ex_rs)) begin
                ForwardA = 2'b01;
            end else if (wb_fwd && (wb_q.write_reg == ex_rs)) begin
                ForwardA = 2'b10;
            end
        end
        if (ex_q.valid && ex_uses_rt) begin
            if (mem_fwd && (mem_q.write_reg == ex_rt)) begin
                ForwardB = 2'b01;
            end else if (wb_fwd && (wb_q.write_reg == ex_rt)) begin
                ForwardB = 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            ex_q       <= '0;
            mem_q      <= '0;
            wb_q       <= '0;
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_uses_rs <= 1'b0;
            ex_uses_rt <= 1'b0;
        end else begin
            wb_q <= mem_q;
            if (Branch) begin
                ex_q       <= '0;
                mem_q      <= '0;
                ex_rs      <= 5'd0;
                ex_rt      <= 5'd0;
                ex_uses_rs <= 1'b0;
                ex_uses_rt <= 1'b0;
            end else if (ControlSrc) begin
                ex_q       <= '0;
                mem_q      <= ex_q;
                ex_rs      <= 5'd0;
                ex_rt      <= 5'd0;
                ex_uses_rs <= 1'b0;
                ex_uses_rt <= 1'b0;
            end else begin
                ex_q       <= id_s;
                mem_q      <= ex_q;
                ex_rs      <= ID_Rs;
                ex_rt      <= ID_Rt;
                ex_uses_rs <= ID_UsesRs;
                ex_uses_rt <= ID_UsesRt;
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
            Halted     <= 1'b0;
        end else begin
            if (ControlSrc && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_ONE;
            end
            if (Branch && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
            if (wb_q.valid && wb_q.halt) begin
                Halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

    logic        CLK;
    logic        Reset;
    logic        ID_Valid;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UsesRs;
    logic        ID_UsesRt;
    logic [4:0]  ID_WriteReg;
    logic        ID_RegWre;
    logic        ID_MemRead;
    logic        ID_Halt;
    logic        MEM_BranchTaken;
    logic        Branch;
    logic        ControlSrc;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;
    logic        Halted;

    logic        sat_Branch;
    logic        sat_ControlSrc;
    logic [1:0]  sat_ForwardA;
    logic [1:0]  sat_ForwardB;
    logic [1:0]  sat_StallCount;
    logic [1:0]  sat_FlushCount;
    logic        sat_Halted;

    int passed = 0;
    int total  = 0;

    hazard_unit #(.CNT_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg),
        .ID_RegWre(ID_RegWre), .ID_MemRead(ID_MemRead), .ID_Halt(ID_Halt),
        .MEM_BranchTaken(MEM_BranchTaken), .Branch(Branch), .ControlSrc(ControlSrc),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .StallCount(StallCount),
        .FlushCount(FlushCount), .Halted(Halted)
    );

    hazard_unit #(.CNT_W(2)) sat (
        .CLK(CLK), .Reset(Reset), .ID_Valid(ID_Valid), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
        .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_WriteReg(ID_WriteReg),
        .ID_RegWre(ID_RegWre), .ID_MemRead(ID_MemRead), .ID_Halt(ID_Halt),
        .MEM_BranchTaken(MEM_BranchTaken), .Branch(sat_Branch), .ControlSrc(sat_ControlSrc),
        .ForwardA(sat_ForwardA), .ForwardB(sat_ForwardB), .StallCount(sat_StallCount),
        .FlushCount(sat_FlushCount), .Halted(sat_Halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] wr,
                          input logic wre, input logic mr, input logic halt);
        ID_Valid    = v;
        ID_Rs       = rs;
        ID_Rt       = rt;
        ID_UsesRs   = urs;
        ID_UsesRt   = urt;
        ID_WriteReg = wr;
        ID_RegWre   = wre;
        ID_MemRead  = mr;
        ID_Halt     = halt;
    endtask

    task automatic bubble;
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset;
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        bubble();
        MEM_BranchTaken = 1'b0;
        #3;
        total++;
        if ({Branch, ControlSrc, ForwardA, ForwardB, Halted} !== 7'd0) begin
            $display("FAIL reset_outputs: got %b want 0000000", {Branch, ControlSrc, ForwardA, ForwardB, Halted});
        end else passed++;
        total++;
        if ({StallCount, FlushCount} !== 32'd0) begin
            $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", StallCount, FlushCount);
        end else passed++;
        #9;
        Reset = 1'b1;
    endtask

    task automatic test_load_use;
        pulse_reset();
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (ControlSrc !== 1'b1) $display("FAIL load_use_stall: got %b want 1", ControlSrc);
        else passed++;
        step();
        #1;
        total++;
        if (ControlSrc !== 1'b0 || StallCount !== 16'd1) begin
            $display("FAIL load_use_after: got ctrl=%b stall=%0d want 0 1", ControlSrc, StallCount);
        end else passed++;
        step();
        bubble();
        #1;
        total++;
        if (ForwardA !== 2'b10 || ForwardB !== 2'b00) begin
            $display("FAIL load_use_fwd: got A=%b B=%b want 10 00", ForwardA, ForwardB);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        pulse_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (ControlSrc !== 1'b0) $display("FAIL alu_no_stall: got %b want 0", ControlSrc);
        else passed++;
        step();
        bubble();
        #1;
        total++;
        if (ForwardA !== 2'b01 || ForwardB !== 2'b01) begin
            $display("FAIL fwd_mem: got A=%b B=%b want 01 01", ForwardA, ForwardB);
        end else passed++;

        pulse_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        step();
        bubble();
        #1;
        total++;
        if (ForwardA !== 2'b10 || ForwardB !== 2'b10) begin
            $display("FAIL fwd_wb: got A=%b B=%b want 10 10", ForwardA, ForwardB);
        end else passed++;
    endtask

    task automatic test_mem_priority;
        for (int z = 0; z < 2; z++) begin
            logic [4:0] r;
            logic [1:0] exp_a;
            r     = (z == 0) ? 5'd10 : 5'd0;
            exp_a = (z == 0) ? 2'b01 : 2'b00;
            pulse_reset();
            set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, r, 1'b1, 1'b0, 1'b0);
            step();
            set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, r, 1'b1, 1'b0, 1'b0);
            step();
            set_id(1'b1, r, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
            step();
            bubble();
            #1;
            total++;
            if (ForwardA !== exp_a || ForwardB !== 2'b00) begin
                $display("FAIL mem_priority_r%0d: got A=%b B=%b want %b 00", r, ForwardA, ForwardB, exp_a);
            end else passed++;
        end
    endtask

    task automatic test_branch_collision;
        pulse_reset();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        MEM_BranchTaken = 1'b1;
        #1;
        total++;
        if (Branch !== 1'b1 || ControlSrc !== 1'b0) begin
            $display("FAIL branch_priority: got branch=%b ctrl=%b want 1 0", Branch, ControlSrc);
        end else passed++;
        step();
        MEM_BranchTaken = 1'b0;
        #1;
        total++;
        if (FlushCount !== 16'd1 || StallCount !== 16'd0) begin
            $display("FAIL branch_counts: got flush=%0d stall=%0d want 1 0", FlushCount, StallCount);
        end else passed++;
        total++;
        if ({Branch, ControlSrc, ForwardA, ForwardB} !== 6'd0) begin
            $display("FAIL branch_flushed: got %b want 000000", {Branch, ControlSrc, ForwardA, ForwardB});
        end else passed++;
        step();
        bubble();
        #1;
        total++;
        if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
            $display("FAIL branch_no_fwd: got A=%b B=%b want 00 00", ForwardA, ForwardB);
        end else passed++;
    endtask

    task automatic test_halt_reset;
        pulse_reset();
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        bubble();
        for (int e = 2; e <= 5; e++) begin
            logic exp_h;
            step();
            exp_h = (e >= 4);
            total++;
            if (Halted !== exp_h) $display("FAIL halt_edge%0d: got %b want %b", e, Halted, exp_h);
            else passed++;
        end
        set_id(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        step();
        bubble();
        #1;
        total++;
        if (Halted !== 1'b1 || StallCount !== 16'd1 || ForwardA !== 2'b10) begin
            $display("FAIL pre_reset: got halt=%b stall=%0d A=%b want 1 1 10", Halted, StallCount, ForwardA);
        end else passed++;
        Reset = 1'b0;
        #1;
        total++;
        if ({Halted, ForwardA, ForwardB, ControlSrc, Branch} !== 7'd0 || StallCount !== 16'd0) begin
            $display("FAIL async_reset: got %b stall=%0d want 0000000 0",
                     {Halted, ForwardA, ForwardB, ControlSrc, Branch}, StallCount);
        end else passed++;
        Reset = 1'b1;
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step();
        set_id(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        step();
        bubble();
        #1;
        total++;
        if (ForwardA !== 2'b01) $display("FAIL post_reset_fwd: got %b want 01", ForwardA);
        else passed++;
    endtask

    task automatic test_saturation;
        pulse_reset();
        set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_c;
            exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
            #1;
            total++;
            if (ControlSrc !== 1'b1) $display("FAIL sat_stall%0d: got %b want 1", i, ControlSrc);
            else passed++;
            step();
            total++;
            if (sat_StallCount !== exp_c) $display("FAIL sat_count%0d: got %0d want %0d", i, sat_StallCount, exp_c);
            else passed++;
            step();
        end
        total++;
        if (StallCount !== 16'd5) $display("FAIL wide_count: got %0d want 5", StallCount);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_mem_priority();
        test_branch_collision();
        test_halt_reset();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
